// File: rtl/mem_acc_pkg.sv
// Shared types and constants for the data-memory access sequencer.
package mem_acc_pkg;

   localparam int ADDR_W_DEF = 6;
   localparam int DATA_W_DEF = 32;
   localparam int LEN_W_DEF  = 4;

   // Sequencer states.
   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      WRITE   = 3'd1,
      RD_ADDR = 3'd2,
      RD_WAIT = 3'd3,
      RD_RESP = 3'd4
   } state_e;

   // Write-data source encodings carried on MW_Data_s.
   localparam logic [1:0] WSEL_SRC0 = 2'd0;
   localparam logic [1:0] WSEL_SRC1 = 2'd1;
   localparam logic [1:0] WSEL_SRC2 = 2'd2;
   localparam logic [1:0] WSEL_SRC3 = 2'd3;

endpackage

// File: rtl/mem_acc_addr_gen.sv
// Loadable wrapping word-address counter plus beat down-counter.
// 'last' is high while the current beat is the final one of the burst.
module mem_acc_addr_gen
   import mem_acc_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int LEN_W  = LEN_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic              step,
   input  logic [ADDR_W-1:0] load_addr,
   input  logic [LEN_W-1:0]  load_len,
   output logic [ADDR_W-1:0] addr,
   output logic              last
);

   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [LEN_W-1:0]  cnt_q,  cnt_d;

   // Load on request acceptance, otherwise advance one beat per step.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      addr_d = addr_q;
      cnt_d  = cnt_q;
      if (load) begin
         addr_d = load_addr;
         cnt_d  = load_len;
      end else if (step) begin
         addr_d = addr_q + ADDR_W'(1);   // wraps naturally at 2^ADDR_W
         cnt_d  = cnt_q - LEN_W'(1);
      end
   end

   // Address and beat-count registers.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      if (!rst_n) begin
         addr_q <= '0;
         cnt_q  <= '0;
      end else begin
         addr_q <= addr_d;
         cnt_q  <= cnt_d;
      end
   end

   assign addr = addr_q;
   assign last = (cnt_q == '0);

endmodule

// File: rtl/mem_access_ctrl.sv
// Data-memory access sequencer: single/burst reads and writes over a
// valid/ready request channel, read data returned on a response channel.
// Optional build macro MEM_ACC_STATS_EN adds saturating beat counters.
module mem_access_ctrl
   import mem_acc_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF,
   parameter int RD_LAT = 1,            // legal 1..3
   parameter int LEN_W  = LEN_W_DEF
) (
   input  logic              clk_dm,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [1:0]        req_wsel,
   input  logic [LEN_W-1:0]  req_len,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_data,
   output logic              rsp_last,
   output logic [ADDR_W-1:0] DM_Addr,
   output logic [1:0]        MW_Data_s,
   output logic              Mem_Write,
   input  logic [DATA_W-1:0] M_R_Data,
   output logic              busy
`ifdef MEM_ACC_STATS_EN
   ,
   output logic [15:0]       wr_beats,
   output logic [15:0]       rd_beats
`endif
);

   localparam logic [1:0] LAT_INIT = 2'(RD_LAT - 1);

   state_e            state_q, state_d;
   logic              mem_write_q, mem_write_d;
   logic [1:0]        mw_data_s_q, mw_data_s_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic              rsp_last_q, rsp_last_d;
   logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
   logic [1:0]        lat_cnt_q, lat_cnt_d;

   logic req_hs, ag_load, ag_step, ag_last, capture;

   mem_acc_addr_gen #(
      .ADDR_W (ADDR_W),
      .LEN_W  (LEN_W)
   ) u_addr_gen (
      .clk       (clk_dm),
      .rst_n     (rst_n),
      .load      (ag_load),
      .step      (ag_step),
      .load_addr (req_addr),
      .load_len  (req_len),
      .addr      (DM_Addr),
      .last      (ag_last)
   );

   // State register.
   always_ff @(posedge clk_dm or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (req_valid) state_d = req_we ? WRITE : RD_ADDR;
         WRITE:   if (ag_last) state_d = IDLE;
         RD_ADDR: state_d = RD_WAIT;
         RD_WAIT: if (lat_cnt_q == 2'd0) state_d = RD_RESP;
         RD_RESP: if (rsp_ready) state_d = ag_last ? IDLE : RD_ADDR;
         default: state_d = IDLE;
      endcase
   end

   // Output and datapath next values; memory-side and rsp outputs are registered.
   always_comb begin
      req_hs      = (state_q == IDLE) && req_valid;
      capture     = (state_q == RD_WAIT) && (lat_cnt_q == 2'd0);
      ag_load     = req_hs;
      ag_step     = !ag_last && ((state_q == WRITE) || ((state_q == RD_RESP) && rsp_ready));
      mem_write_d = (state_d == WRITE);
      rsp_valid_d = (state_d == RD_RESP);
      mw_data_s_d = (req_hs && req_we) ? req_wsel : mw_data_s_q;
      lat_cnt_d   = lat_cnt_q;
      if (state_q == RD_ADDR)
         lat_cnt_d = LAT_INIT;
      else if ((state_q == RD_WAIT) && (lat_cnt_q != 2'd0))
         lat_cnt_d = lat_cnt_q - 2'd1;
      rsp_data_d = rsp_data_q;
      rsp_last_d = rsp_last_q;
      if (capture) begin
         rsp_data_d = M_R_Data;
         rsp_last_d = ag_last;
      end
   end

   // Datapath and output registers.
   always_ff @(posedge clk_dm or negedge rst_n) begin
      if (!rst_n) begin
         mem_write_q <= 1'b0;
         mw_data_s_q <= 2'd0;
         rsp_valid_q <= 1'b0;
         rsp_last_q  <= 1'b0;
         rsp_data_q  <= '0;
         lat_cnt_q   <= 2'd0;
      end else begin
         mem_write_q <= mem_write_d;
         mw_data_s_q <= mw_data_s_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_last_q  <= rsp_last_d;
         rsp_data_q  <= rsp_data_d;
         lat_cnt_q   <= lat_cnt_d;
      end
   end

   assign req_ready = (state_q == IDLE);
   assign busy      = (state_q != IDLE);
   assign Mem_Write = mem_write_q;
   assign MW_Data_s = mw_data_s_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_last  = rsp_last_q;
   assign rsp_data  = rsp_data_q;

`ifdef MEM_ACC_STATS_EN
   logic [15:0] wr_beats_q, wr_beats_d;
   logic [15:0] rd_beats_q, rd_beats_d;

   // Saturating counts of completed write beats and read handshakes.
   always_comb begin
      wr_beats_d = wr_beats_q;
      rd_beats_d = rd_beats_q;
      if ((state_q == WRITE) && (wr_beats_q != 16'hFFFF))
         wr_beats_d = wr_beats_q + 16'd1;
      if ((state_q == RD_RESP) && rsp_ready && (rd_beats_q != 16'hFFFF))
         rd_beats_d = rd_beats_q + 16'd1;
   end

   // Statistics registers.
   always_ff @(posedge clk_dm or negedge rst_n) begin
      if (!rst_n) begin
         wr_beats_q <= 16'd0;
         rd_beats_q <= 16'd0;
      end else begin
         wr_beats_q <= wr_beats_d;
         rd_beats_q <= rd_beats_d;
      end
   end

   assign wr_beats = wr_beats_q;
   assign rd_beats = rd_beats_q;
`endif

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
Upstream sequencer for the data memory. It accepts single or burst read/write requests over a valid/ready interface and drives the memory port signals DM_Addr[7:2], MW_Data_s and Mem_Write. It captures M_R_Data after a fixed read latency and returns it over a valid/ready response channel. It sits between the CPU/test driver and the memory block, and both share clk_dm.

Parameters:
ADDR_W, 6, word-address width; drives DM_Addr[7:2].
DATA_W, 32, memory read-data width.
RD_LAT, 1, cycles from DM_Addr driven to M_R_Data valid; legal range 1..3.
LEN_W, 4, burst-length field width; a burst is req_len+1 beats, so 1..16.

Ports:
clk_dm  in  1  clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
req_valid  in  1  request valid.
req_ready  out  1  request accepted when req_valid & req_ready.
req_we  in  1  1 = write burst, 0 = read burst.
req_addr  in  ADDR_W  start word address.
req_wsel  in  2  write-data source select, passed to MW_Data_s.
req_len  in  LEN_W  beats minus one.
rsp_valid  out  1  read data valid.
rsp_ready  in  1  consumer accepts read data.
rsp_data  out  DATA_W  captured read word.
rsp_last  out  1  marks the final beat of a read burst.
DM_Addr  out  ADDR_W  memory word address.
MW_Data_s  out  2  memory write-data select.
Mem_Write  out  1  memory write enable.
M_R_Data  in  DATA_W  memory read data.
busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (async, rst_n=0): state=IDLE. DM_Addr, MW_Data_s, Mem_Write, rsp_valid, rsp_last, rsp_data and busy all go to 0. Reset during a burst abandons the remaining beats, and Mem_Write falls immediately.
- Memory-side outputs and rsp_* are registered. req_ready = (state==IDLE) and is combinational from state.
- FSM states: IDLE, WRITE, RD_ADDR, RD_WAIT, RD_RESP.
- IDLE: on handshake, latch addr, wsel and len, and load beat counter = len. Go to WRITE if req_we=1, else RD_ADDR.
- WRITE:
  - Mem_Write=1, MW_Data_s=wsel and DM_Addr=current address for exactly len+1 consecutive cycles.
  - The first beat is the cycle after acceptance.
  - The address increments each beat, wrapping 2^ADDR_W-1 to 0.
  - After the last beat go to IDLE with Mem_Write=0. Writes produce no response.
- RD_ADDR: drive DM_Addr with Mem_Write=0, then go to RD_WAIT.
- RD_WAIT: count RD_LAT cycles, then capture M_R_Data into rsp_data, set rsp_valid=1, set rsp_last=(counter==0), and go to RD_RESP.
- RD_RESP:
  - Hold rsp_data and rsp_last stable while rsp_valid & !rsp_ready.
  - On handshake: clear rsp_valid. If this was the last beat go to IDLE; otherwise increment the address with wrap, decrement the counter and go to RD_ADDR.
- Peak read rate is one beat per RD_LAT+2 cycles when rsp_ready is held high.
- len=0 gives a single beat. A request arriving on the same cycle the FSM returns to IDLE is not accepted that cycle (req_ready is still 0).
- MW_Data_s retains the last written value while idle. Mem_Write is never 1 outside WRITE.

Optional Feature:
MEM_ACC_STATS_EN
- Defined: adds output ports wr_beats[15:0] and rd_beats[15:0]. They count completed write beats and completed read handshakes, saturate at 16'hFFFF and reset to 0.
- Undefined: these ports and counters are absent. Behaviour is otherwise identical.

Decomposition:
- Shared package mem_acc_pkg holds:
  - state enum (IDLE, WRITE, RD_ADDR, RD_WAIT, RD_RESP)
  - WSEL encodings for the 2-bit MW_Data_s
  - default ADDR_W and DATA_W constants
- One sub-module, mem_acc_addr_gen: loadable wrapping address counter plus beat-down-counter with a last flag. Everything else stays in the top module.

Test Plan:
- Reset mid write-burst (addr 5, len 7, assert rst_n=0 at beat 3) -> Mem_Write=0 asynchronously; all outputs 0; req_ready=1 after release.
- Single write: addr=1, wsel=1, len=0 -> exactly one cycle with Mem_Write=1, DM_Addr=1, MW_Data_s=1; no rsp_valid.
- Write burst with wrap: addr=62, len=3 -> DM_Addr sequence 62, 63, 0, 1 on consecutive cycles with Mem_Write=1.
- Read burst: addr=0, len=1, memory model returning addr-tagged words, RD_LAT=1 -> two responses with rsp_data=word[0] then word[1]; rsp_last=0 then 1.
- Backpressure: hold rsp_ready=0 for 5 cycles on the first read beat -> rsp_data and rsp_valid stable; DM_Addr does not advance.
- With MEM_ACC_STATS_EN: write len=3, then read len=1 -> wr_beats=4, rd_beats=2.
